// File: rtl/trig_sequencer_if.sv
// Handshake/config bundle between the register file, the sync port
// and the trigger burst sequencer.
interface trig_sequencer_if #(
    parameter int _RAM_WIDTH = 32
);
    logic                  io_start;
    logic                  io_abort;
    logic [_RAM_WIDTH-1:0] io_period;
    logic [15:0]           io_repeat;
    logic [_RAM_WIDTH-1:0] io_timeout;
    logic                  io_fbCatch;
    logic                  io_pulseEn;
    logic                  io_busy;
    logic                  io_done;
    logic [15:0]           io_issued;
    logic [15:0]           io_missCount;

    modport master (
        output io_start,
        output io_abort,
        output io_period,
        output io_repeat,
        output io_timeout,
        output io_fbCatch,
        input  io_pulseEn,
        input  io_busy,
        input  io_done,
        input  io_issued,
        input  io_missCount
    );

    modport slave (
        input  io_start,
        input  io_abort,
        input  io_period,
        input  io_repeat,
        input  io_timeout,
        input  io_fbCatch,
        output io_pulseEn,
        output io_busy,
        output io_done,
        output io_issued,
        output io_missCount
    );
endinterface

// File: rtl/trig_sequencer.sv
// Burst sequencer: issues io_pulseEn strobes at a minimum period and
// waits for the sync port feedback edge (or a timeout) after each one.
module trig_sequencer #(
    parameter int _RAM_WIDTH = 32
) (
    input  logic            io_clk,
    input  logic            io_rst,
    trig_sequencer_if.slave io
);
    localparam logic [_RAM_WIDTH-1:0] ONE   = {{(_RAM_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [_RAM_WIDTH-1:0] TWO   = ONE << 1;
    localparam logic [_RAM_WIDTH-1:0] E_MAX = '1;

    typedef enum logic [2:0] {
        IDLE,
        FIRE,
        WAIT_FB,
        GAP,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [_RAM_WIDTH-1:0] period_q, period_d;
    logic [_RAM_WIDTH-1:0] timeout_q, timeout_d;
    logic [_RAM_WIDTH-1:0] elapsed_q, elapsed_d;
    logic [_RAM_WIDTH-1:0] elapsed_inc;
    logic [15:0]           repeat_q, repeat_d;
    logic [15:0]           issued_q, issued_d;
    logic [15:0]           miss_q, miss_d;
    logic                  fb_d1_q;

    logic fb_edge;
    logic timed_out;
    logic gap_over;
    logic more;

    assign fb_edge     = io.io_fbCatch & ~fb_d1_q;
    assign timed_out   = (timeout_q != '0) && (elapsed_q == timeout_q);
    assign gap_over    = elapsed_q >= (period_q - ONE);
    assign more        = issued_q < repeat_q;
    assign elapsed_inc = (elapsed_q == E_MAX) ? elapsed_q : elapsed_q + ONE;

    always_comb begin
        state_d   = state_q;
        period_d  = period_q;
        timeout_d = timeout_q;
        repeat_d  = repeat_q;
        issued_d  = issued_q;
        miss_d    = miss_q;
        elapsed_d = elapsed_q;
        unique case (state_q)
            IDLE: begin
                if (io.io_start) begin
                    period_d  = (io.io_period < TWO) ? TWO : io.io_period;
                    timeout_d = io.io_timeout;
                    repeat_d  = io.io_repeat;
                    miss_d    = '0;
                    if (io.io_repeat == 16'd0) begin
                        issued_d = '0;
                        state_d  = DONE;
                    end else begin
                        // the first strobe is counted as it is issued
                        issued_d  = 16'd1;
                        elapsed_d = '0;
                        state_d   = FIRE;
                    end
                end
            end
            FIRE: begin
                elapsed_d = elapsed_inc;
                state_d   = io.io_abort ? DONE : WAIT_FB;
            end
            WAIT_FB: begin
                elapsed_d = elapsed_inc;
                if (io.io_abort) begin
                    state_d = DONE;
                end else if (fb_edge) begin
                    state_d = GAP;
                end else if (timed_out) begin
                    if (miss_q != 16'hFFFF) begin
                        miss_d = miss_q + 16'd1;
                    end
                    state_d = GAP;
                end
            end
            GAP: begin
                elapsed_d = elapsed_inc;
                if (io.io_abort) begin
                    state_d = DONE;
                end else if (gap_over) begin
                    if (more) begin
                        issued_d  = issued_q + 16'd1;
                        elapsed_d = '0;
                        state_d   = FIRE;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge io_clk or posedge io_rst) begin
        if (io_rst) begin
            state_q   <= IDLE;
            period_q  <= '0;
            timeout_q <= '0;
            repeat_q  <= '0;
            issued_q  <= '0;
            miss_q    <= '0;
            elapsed_q <= '0;
            fb_d1_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            period_q  <= period_d;
            timeout_q <= timeout_d;
            repeat_q  <= repeat_d;
            issued_q  <= issued_d;
            miss_q    <= miss_d;
            elapsed_q <= elapsed_d;
            fb_d1_q   <= io.io_fbCatch;
        end
    end

    assign io.io_pulseEn   = (state_q == FIRE);
    assign io.io_busy      = (state_q != IDLE);
    assign io.io_done      = (state_q == DONE);
    assign io.io_issued    = issued_q;
    assign io.io_missCount = miss_q;
endmodule
